// File: rtl/led_chase_module.sv
// LED chase pattern generator: each accepted rising edge of Step_In advances
// a rotate-left, rotate-right, bounce or blink pattern across the LED bank.
module led_chase_module #(
  parameter int unsigned LED_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Step_In,
  input  logic             En_In,
  input  logic [1:0]       Mode_Sel,
  output logic [LED_W-1:0] LED_Out,
  output logic             Wrap_Out,
  output logic [CNT_W-1:0] Step_Cnt
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

  logic             step_prev_q;
  logic [LED_W-1:0] led_q, led_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  mode_e            mode_sel;
  logic             step_acc;

  assign mode_sel = mode_e'(Mode_Sel);
  assign step_acc = Step_In & ~step_prev_q & En_In;

  always_comb begin
    led_d  = led_q;
    wrap_d = 1'b0;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    if (step_acc) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode_sel != mode_q) begin
        // A mode change restarts the pattern and never flags a wrap
        mode_d = mode_sel;
        dir_d  = DIR_UP;
        led_d  = (mode_sel == MODE_BLINK) ? '1 : LED_ONE;
      end else begin
        unique case (mode_q)
          MODE_ROL: begin
            led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
            wrap_d = led_q[LED_W-1];
          end
          MODE_ROR: begin
            led_d  = {led_q[0], led_q[LED_W-1:1]};
            wrap_d = led_q[0];
          end
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (led_q[LED_W-1]) begin
                led_d  = led_q >> 1;
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d  = led_q << 1;
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          MODE_BLINK: begin
            led_d  = ~led_q;
            wrap_d = ~|led_q;
          end
          default: led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_prev_q <= 1'b0;
      led_q       <= LED_ONE;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= MODE_ROL;
      dir_q       <= DIR_UP;
    end else begin
      step_prev_q <= Step_In;
      led_q       <= led_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
    end
  end

  assign LED_Out  = led_q;
  assign Wrap_Out = wrap_q;
  assign Step_Cnt = cnt_q;

endmodule

// File: tb/tb_led_chase_module.sv
// Scoreboard bench for led_chase_module: a behavioural model pushes expected
// outputs per driven step, popped and compared after the updating clock edge.
module tb_led_chase_module;

  localparam int unsigned LW = 4;
  localparam int unsigned CW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          Step_In = 1'b0;
  logic          En_In = 1'b0;
  logic [1:0]    Mode_Sel = 2'b00;
  logic [LW-1:0] LED_Out;
  logic          Wrap_Out;
  logic [CW-1:0] Step_Cnt;

  led_chase_module #(.LED_W(LW), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .Step_In(Step_In), .En_In(En_In),
    .Mode_Sel(Mode_Sel), .LED_Out(LED_Out), .Wrap_Out(Wrap_Out),
    .Step_Cnt(Step_Cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [LW-1:0] led;
    logic          wrap;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic [LW-1:0] m_led;
  logic [1:0]    m_mode;
  bit            m_up;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_led  = LW'(1);
    m_mode = 2'b00;
    m_up   = 1'b1;
    m_cnt  = '0;
  endtask

  task automatic model_step(input bit en, input logic [1:0] msel);
    exp_t e;
    e.wrap = 1'b0;
    if (en) begin
      m_cnt = m_cnt + 1'b1;
      if (msel != m_mode) begin
        m_mode = msel;
        m_up   = 1'b1;
        m_led  = (msel == 2'b11) ? {LW{1'b1}} : LW'(1);
      end else begin
        case (m_mode)
          2'b00: begin
            e.wrap = m_led[LW-1];
            m_led  = (m_led << 1) | (m_led >> (LW-1));
          end
          2'b01: begin
            e.wrap = m_led[0];
            m_led  = (m_led >> 1) | (m_led << (LW-1));
          end
          2'b10: begin
            if (m_up && m_led[LW-1]) begin
              m_up = 1'b0; e.wrap = 1'b1; m_led = m_led >> 1;
            end else if (!m_up && m_led[0]) begin
              m_up = 1'b1; e.wrap = 1'b1; m_led = m_led << 1;
            end else begin
              m_led = m_up ? (m_led << 1) : (m_led >> 1);
            end
          end
          default: begin
            m_led  = ~m_led;
            e.wrap = (m_led == {LW{1'b1}});
          end
        endcase
      end
    end
    e.led = m_led;
    e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check({tag, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_led"},  32'(LED_Out),  32'(e.led));
      check({tag, "_wrap"}, 32'(Wrap_Out), 32'(e.wrap));
      check({tag, "_cnt"},  32'(Step_Cnt), 32'(e.cnt));
    end
  endtask

  task automatic do_reset();
    Step_In = 1'b0; En_In = 1'b1; Mode_Sel = 2'b00;
    RST = 1'b0; #1; RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    model_reset();
    check("rst_led",  32'(LED_Out),  32'd1);
    check("rst_wrap", 32'(Wrap_Out), 32'd0);
    check("rst_cnt",  32'(Step_Cnt), 32'd0);
  endtask

  // Called 1 time unit after a rising clock edge with Step_In low.
  task automatic pulse(input string tag, input bit en, input logic [1:0] msel);
    Mode_Sel = msel; En_In = en; Step_In = 1'b1;
    model_step(en, msel);
    @(posedge CLK); #1;
    Step_In = 1'b0;
    sb_check(tag);
    @(posedge CLK); #1;
    check({tag, "_wrap_clr"}, 32'(Wrap_Out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] rol_tbl[5];
    logic [LW-1:0] bnc_tbl[8];
    logic [LW-1:0] blk_tbl[4];
    int            wraps;
    rol_tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bnc_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    blk_tbl = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};

    // rotate left
    do_reset();
    wraps = 0;
    for (int i = 0; i < 5; i++) begin
      pulse("rol", 1'b1, 2'b00);
      check("rol_tbl", 32'(LED_Out), 32'(rol_tbl[i]));
    end
    check("rol_cnt", 32'(Step_Cnt), 32'd5);

    // rotate right (mode change then steps)
    do_reset();
    for (int i = 0; i < 6; i++) pulse("ror", 1'b1, 2'b01);

    // bounce
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse("bnc", 1'b1, 2'b10);
      check("bnc_tbl", 32'(LED_Out), 32'(bnc_tbl[i]));
    end

    // blink
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse("blk", 1'b1, 2'b11);
      check("blk_tbl", 32'(LED_Out), 32'(blk_tbl[i]));
    end

    // Mode_Sel change while idle has no effect until next accepted step
    do_reset();
    pulse("idle0", 1'b1, 2'b00);
    Mode_Sel = 2'b01;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_led", 32'(LED_Out), 32'(m_led));

    // held-high Step_In gives exactly one step
    do_reset();
    Mode_Sel = 2'b00; En_In = 1'b1; Step_In = 1'b1;
    model_step(1'b1, 2'b00);
    @(posedge CLK); #1;
    sb_check("hold_first");
    repeat (9) @(posedge CLK);
    model_step(1'b0, 2'b00);
    #1;
    sb_check("hold_rest");
    Step_In = 1'b0;
    @(posedge CLK); #1;
    check("hold_cnt", 32'(Step_Cnt), 32'd1);

    // disabled pulses freeze the pattern
    for (int i = 0; i < 3; i++) pulse("dis", 1'b0, 2'b00);
    check("dis_cnt", 32'(Step_Cnt), 32'd1);

    // rejected edge is not remembered when En_In rises while Step_In stays high
    En_In = 1'b0; Step_In = 1'b1;
    model_step(1'b0, 2'b00);
    @(posedge CLK); #1;
    sb_check("rej_edge");
    En_In = 1'b1;
    model_step(1'b0, 2'b00);
    @(posedge CLK); #1;
    sb_check("rej_late");
    Step_In = 1'b0;
    @(posedge CLK); #1;

    // Step_In high across reset release steps on the first clock
    Step_In = 1'b1; En_In = 1'b1; Mode_Sel = 2'b00;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    model_step(1'b1, 2'b00);
    @(posedge CLK); #1;
    Step_In = 1'b0;
    sb_check("rst_rel");

    // step counter wraps after 256 accepted steps
    do_reset();
    for (int i = 0; i < 256; i++) pulse("cnt", 1'b1, 2'b00);
    check("cnt_wrap", 32'(Step_Cnt), 32'd0);

    // asynchronous reset during a wrap pulse
    do_reset();
    for (int i = 0; i < 3; i++) pulse("pre", 1'b1, 2'b00);
    Step_In = 1'b1;
    model_step(1'b1, 2'b00);
    @(posedge CLK); #1;
    Step_In = 1'b0;
    sb_check("wrap_before_rst");
    #2; RST = 1'b1; #1;
    check("async_led",  32'(LED_Out),  32'd1);
    check("async_wrap", 32'(Wrap_Out), 32'd0);
    check("async_cnt",  32'(Step_Cnt), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
